// File: rtl/dcache_wb_controller_pkg.sv
// Shared types for the write-back D-cache controller: FSM state encoding.
package dcache_wb_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_EVICT  = 3'd2,
    ST_REFILL = 3'd3,
    ST_FILL   = 3'd4
  } dc_state_e;

endpackage

// File: rtl/dcache_wb_controller_wb_buffer.sv
// One-entry victim write-back buffer: captures a dirty line in one cycle and
// drains it to memory in the background, holding the write until it completes.
module dcache_wb_controller_wb_buffer #(
  parameter int BADDR_W = 27,
  parameter int BLOCK_W = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               capture,
  input  logic [BADDR_W-1:0] cap_addr,
  input  logic [BLOCK_W-1:0] cap_data,
  input  logic               drain_open,
  input  logic               mem_write_done,
  output logic               wb_valid,
  output logic [BADDR_W-1:0] wb_addr,
  output logic [BLOCK_W-1:0] wb_data,
  output logic               mem_wen
);

  logic drain_hold;

  // A started write stays up regardless of what the FSM does next.
  assign mem_wen = wb_valid & (drain_hold | drain_open);

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      drain_hold <= 1'b0;
    end else begin
      drain_hold <= mem_wen & ~mem_write_done;
      if (capture) begin
        wb_valid <= 1'b1;
        wb_addr  <= cap_addr;
        wb_data  <= cap_data;
      end else if (mem_wen && mem_write_done) begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dcache_wb_controller.sv
// Write-back / write-allocate L1 D-cache controller with a one-entry victim
// buffer and store-merging refill.
module dcache_wb_controller
  import dcache_wb_controller_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int WORD_BYTES  = 4,
  parameter int BLOCK_WORDS = 8,
  localparam int WORD_W      = 8 * WORD_BYTES,
  localparam int BLOCK_BYTES = WORD_BYTES * BLOCK_WORDS,
  localparam int BLOCK_W     = 8 * BLOCK_BYTES,
  localparam int OFF_W       = $clog2(BLOCK_BYTES),
  localparam int BYTE_OFF_W  = $clog2(WORD_BYTES),
  localparam int WIDX_W      = $clog2(BLOCK_WORDS),
  localparam int BADDR_W     = ADDR_W - OFF_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ren,
  input  logic                   wen,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [WORD_BYTES-1:0]  byteSelectVector,
  input  logic [WORD_W-1:0]      din,
  output logic                   stall,
  output logic [WORD_W-1:0]      dout,
  output logic [BADDR_W-1:0]     blockAddr,
  input  logic                   cacheHit,
  input  logic                   cacheDirtyBit,
  input  logic [BADDR_W-1:0]     cacheVictimBAddr,
  input  logic [BLOCK_W-1:0]     cacheDout,
  output logic                   cacheRen,
  output logic                   cacheWen,
  output logic                   cacheMemWen,
  output logic                   cacheSetDirty,
  output logic [BLOCK_BYTES-1:0] cacheBytesAccess,
  output logic [BLOCK_W-1:0]     cacheDin,
  output logic                   memRen,
  output logic                   memWen,
  input  logic                   memReadReady,
  input  logic                   memWriteDone,
  output logic [BADDR_W-1:0]     memBlockAddr,
  output logic [BLOCK_W-1:0]     memDin,
  input  logic [BLOCK_W-1:0]     memDout,
  output logic                   wbPending,
  output dc_state_e              dbg_state
);

  dc_state_e          state, state_next;
  logic [BLOCK_W-1:0] fill_data;
  logic [BLOCK_W-1:0] merged;
  logic [WIDX_W-1:0]  word_idx;
  logic               rd_req, wr_req, req, miss;
  logic               capture, drain_open;
  logic               wb_valid;
  logic [BADDR_W-1:0] wb_addr;
  logic [BLOCK_W-1:0] wb_data;
  logic               unused_byte_off;

  assign unused_byte_off = ^addr[BYTE_OFF_W-1:0];

  assign blockAddr = addr[ADDR_W-1:OFF_W];
  assign word_idx  = addr[OFF_W-1:BYTE_OFF_W];
  assign dout      = cacheDout[int'(word_idx) * WORD_W +: WORD_W];

  assign rd_req    = ren & ~wen;
  assign wr_req    = wen & ~ren;
  assign req       = ren ^ wen;
  assign miss      = (state == ST_IDLE) & req & ~cacheHit;
  assign wbPending = wb_valid;
  assign dbg_state = state;

  dcache_wb_controller_wb_buffer #(
    .BADDR_W(BADDR_W),
    .BLOCK_W(BLOCK_W)
  ) u_wb_buffer (
    .clock          (clock),
    .reset          (reset),
    .capture        (capture),
    .cap_addr       (cacheVictimBAddr),
    .cap_data       (cacheDout),
    .drain_open     (drain_open),
    .mem_write_done (memWriteDone),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .mem_wen        (memWen)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      fill_data <= '0;
    end else begin
      state <= state_next;
      if (state == ST_REFILL && memReadReady) fill_data <= memDout;
    end
  end

  // Store miss: overlay the enabled store bytes onto the refill block.
  always_comb begin
    merged = fill_data;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (byteSelectVector[b]) merged[int'(word_idx) * WORD_W + 8 * b +: 8] = din[8 * b +: 8];
    end
  end

  always_comb begin
    state_next       = state;
    stall            = 1'b0;
    cacheRen         = 1'b0;
    cacheWen         = 1'b0;
    cacheMemWen      = 1'b0;
    cacheSetDirty    = 1'b0;
    cacheBytesAccess = '0;
    cacheDin         = '0;
    memRen           = 1'b0;
    capture          = 1'b0;
    drain_open       = 1'b0;
    case (state)
      ST_IDLE: begin
        cacheRen = rd_req;
        cacheWen = wr_req;
        if (wr_req) begin
          cacheBytesAccess = BLOCK_BYTES'(byteSelectVector) << (int'(word_idx) * WORD_BYTES);
          cacheDin         = {BLOCK_WORDS{din}};
        end
        if (miss) begin
          stall = 1'b1;
          // Draining first also keeps a refill from reading a block still in the buffer.
          if (wb_valid)           state_next = ST_DRAIN;
          else if (cacheDirtyBit) state_next = ST_EVICT;
          else                    state_next = ST_REFILL;
        end else begin
          drain_open = 1'b1;
        end
      end
      ST_DRAIN: begin
        stall      = 1'b1;
        drain_open = 1'b1;
        if (memWen && memWriteDone) state_next = ST_IDLE;
      end
      ST_EVICT: begin
        stall      = 1'b1;
        capture    = 1'b1;
        state_next = ST_REFILL;
      end
      ST_REFILL: begin
        stall  = 1'b1;
        memRen = 1'b1;
        if (memReadReady) state_next = ST_FILL;
      end
      ST_FILL: begin
        stall            = 1'b1;
        cacheMemWen      = 1'b1;
        cacheBytesAccess = '1;
        cacheDin         = wr_req ? merged : fill_data;
        cacheSetDirty    = wr_req;
        drain_open       = 1'b1;
        state_next       = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign memBlockAddr = memRen ? blockAddr : (memWen ? wb_addr : '0);
  assign memDin       = memWen ? wb_data : '0;

endmodule

// File: tb/tb_dcache_wb_controller.sv
// Directed bench for dcache_wb_controller with a fixed-latency block memory model.
module tb_dcache_wb_controller;
  import dcache_wb_controller_pkg::*;

  localparam int CW      = 256;
  localparam int BADDR_W = 27;

  logic              clock;
  logic              reset;
  logic              ren, wen;
  logic [31:0]       addr;
  logic [3:0]        byteSelectVector;
  logic [31:0]       din;
  logic              stall;
  logic [31:0]       dout;
  logic [BADDR_W-1:0] blockAddr;
  logic              cacheHit, cacheDirtyBit;
  logic [BADDR_W-1:0] cacheVictimBAddr;
  logic [255:0]      cacheDout;
  logic              cacheRen, cacheWen, cacheMemWen, cacheSetDirty;
  logic [31:0]       cacheBytesAccess;
  logic [255:0]      cacheDin;
  logic              memRen, memWen;
  logic              memReadReady, memWriteDone;
  logic [BADDR_W-1:0] memBlockAddr;
  logic [255:0]      memDin;
  logic [255:0]      memDout;
  logic              wbPending;
  dc_state_e         dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  dcache_wb_controller dut (
    .clock(clock), .reset(reset), .ren(ren), .wen(wen), .addr(addr),
    .byteSelectVector(byteSelectVector), .din(din), .stall(stall), .dout(dout),
    .blockAddr(blockAddr), .cacheHit(cacheHit), .cacheDirtyBit(cacheDirtyBit),
    .cacheVictimBAddr(cacheVictimBAddr), .cacheDout(cacheDout), .cacheRen(cacheRen),
    .cacheWen(cacheWen), .cacheMemWen(cacheMemWen), .cacheSetDirty(cacheSetDirty),
    .cacheBytesAccess(cacheBytesAccess), .cacheDin(cacheDin), .memRen(memRen),
    .memWen(memWen), .memReadReady(memReadReady), .memWriteDone(memWriteDone),
    .memBlockAddr(memBlockAddr), .memDin(memDin), .memDout(memDout),
    .wbPending(wbPending), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  // ---------------- memory model: 3-cycle read, wr_lat-cycle write ----------------
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   wr_lat = 3;
  logic rd_pulse = 1'b0;
  logic spur_rd  = 1'b0;

  always @(posedge clock) begin
    #2;
    if (reset) begin
      rd_cnt = 0; wr_cnt = 0; rd_pulse = 1'b0; memWriteDone = 1'b0;
    end else begin
      if (memRen && !rd_pulse) begin
        rd_cnt++;
        rd_pulse = (rd_cnt == 3);
      end else begin
        rd_cnt = 0; rd_pulse = 1'b0;
      end
      if (memWen && !memWriteDone) begin
        wr_cnt++;
        memWriteDone = (wr_cnt == wr_lat);
      end else begin
        wr_cnt = 0; memWriteDone = 1'b0;
      end
    end
    memReadReady = rd_pulse | spur_rd;
  end

  // ---------------- protocol monitor ----------------
  logic               prev_hold = 1'b0;
  logic [BADDR_W-1:0] prev_addr = '0;
  logic               rst_seen  = 1'b1;

  always @(posedge clock) rst_seen = reset;

  always @(negedge clock) begin
    if (!reset) begin
      check("mem_rw_excl", CW'(memRen & memWen), CW'(0));
      if (cacheMemWen) check("fill_strobe_state", CW'(dbg_state), CW'(ST_FILL));
      if (prev_hold && !rst_seen) begin
        check("wen_hold", CW'(memWen), CW'(1));
        check("wen_addr_hold", CW'(memBlockAddr), CW'(prev_addr));
      end
      prev_hold = memWen & ~memWriteDone;
      prev_addr = memBlockAddr;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [255:0] hit_blk, refill_blk, victim_blk, victim2_blk, exp_merge;
  int n;

  task automatic refill_loop(input logic [BADDR_W-1:0] exp_addr);
    n = 0;
    while (dbg_state == ST_REFILL && n < 10) begin
      check("refill_memren", CW'(memRen), CW'(1));
      check("refill_addr", CW'(memBlockAddr), CW'(exp_addr));
      n++;
      next_cyc();
      sample();
    end
    check("refill_cycles", CW'(n), CW'(3));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      hit_blk[i*32 +: 32]     = 32'h1111_1111 * 32'(i);
      refill_blk[i*32 +: 32]  = 32'hC0DE_0000 | 32'(i);
      victim_blk[i*32 +: 32]  = 32'h5A5A_0000 | 32'(i);
      victim2_blk[i*32 +: 32] = 32'h7E7E_0000 | 32'(i);
    end
    hit_blk[95:64] = 32'hDEADBEEF;
    exp_merge = refill_blk;
    exp_merge[95:64] = 32'hC0DE_3344;
    memDout = refill_blk;

    ren = 0; wen = 0; addr = 0; byteSelectVector = 0; din = 0;
    cacheHit = 0; cacheDirtyBit = 0; cacheVictimBAddr = 0; cacheDout = 0;
    memReadReady = 0; memWriteDone = 0;

    // Reset state
    reset = 1;
    next_cyc(); next_cyc();
    sample();
    check("rst_state", CW'(dbg_state), CW'(ST_IDLE));
    check("rst_stall", CW'(stall), CW'(0));
    check("rst_memren", CW'(memRen), CW'(0));
    check("rst_memwen", CW'(memWen), CW'(0));
    check("rst_wbpending", CW'(wbPending), CW'(0));
    check("rst_fill", CW'(cacheMemWen), CW'(0));
    check("rst_memaddr", CW'(memBlockAddr), CW'(0));
    next_cyc();
    reset = 0;

    // Load hit, word 2 of block 0x40
    ren = 1; addr = 32'h48; cacheHit = 1; cacheDout = hit_blk;
    sample();
    check("hit_dout", CW'(dout), CW'(32'hDEADBEEF));
    check("hit_stall", CW'(stall), CW'(0));
    check("hit_cacheren", CW'(cacheRen), CW'(1));
    check("hit_cachewen", CW'(cacheWen), CW'(0));
    check("hit_blockaddr", CW'(blockAddr), CW'(2));
    check("hit_memren", CW'(memRen), CW'(0));

    // Store hit, word 1
    next_cyc();
    ren = 0; wen = 1; addr = 32'h44; byteSelectVector = 4'b0110; din = 32'hA5A5_1234;
    sample();
    check("st_cachewen", CW'(cacheWen), CW'(1));
    check("st_cacheren", CW'(cacheRen), CW'(0));
    check("st_bytes", CW'(cacheBytesAccess), CW'(32'h0000_0060));
    check("st_din", cacheDin, {8{32'hA5A5_1234}});
    check("st_stall", CW'(stall), CW'(0));

    // ren=wen=1 is no request, even with no hit
    next_cyc();
    ren = 1; wen = 1; cacheHit = 0;
    sample();
    check("both_cacheren", CW'(cacheRen), CW'(0));
    check("both_cachewen", CW'(cacheWen), CW'(0));
    check("both_stall", CW'(stall), CW'(0));
    check("both_bytes", CW'(cacheBytesAccess), CW'(0));

    // Spurious memReadReady in IDLE is ignored
    next_cyc();
    ren = 0; wen = 0; spur_rd = 1;
    sample();
    next_cyc();
    spur_rd = 0;
    sample();
    check("spur_state", CW'(dbg_state), CW'(ST_IDLE));
    check("spur_fill", CW'(cacheMemWen), CW'(0));

    // Clean load miss
    next_cyc();
    ren = 1; wen = 0; addr = 32'h100; cacheHit = 0; cacheDirtyBit = 0;
    sample();
    check("cmiss_stall", CW'(stall), CW'(1));
    check("cmiss_state", CW'(dbg_state), CW'(ST_IDLE));
    check("cmiss_memren0", CW'(memRen), CW'(0));
    next_cyc();
    sample();
    refill_loop(27'h8);
    check("cmiss_fill_state", CW'(dbg_state), CW'(ST_FILL));
    check("cmiss_fill_wen", CW'(cacheMemWen), CW'(1));
    check("cmiss_fill_bytes", CW'(cacheBytesAccess), CW'(32'hFFFF_FFFF));
    check("cmiss_fill_din", cacheDin, refill_blk);
    check("cmiss_fill_dirty", CW'(cacheSetDirty), CW'(0));
    check("cmiss_fill_stall", CW'(stall), CW'(1));
    next_cyc();
    cacheHit = 1;
    sample();
    check("cmiss_done_state", CW'(dbg_state), CW'(ST_IDLE));
    check("cmiss_done_stall", CW'(stall), CW'(0));

    // Dirty store miss with victim 0x12
    next_cyc();
    ren = 0; wen = 1; addr = 32'h208; din = 32'h1122_3344; byteSelectVector = 4'b0011;
    cacheHit = 0; cacheDirtyBit = 1; cacheVictimBAddr = 27'h12; cacheDout = victim_blk;
    sample();
    check("dmiss_stall", CW'(stall), CW'(1));
    next_cyc();
    sample();
    check("dmiss_evict", CW'(dbg_state), CW'(ST_EVICT));
    check("dmiss_evict_wbp", CW'(wbPending), CW'(0));
    next_cyc();
    sample();
    check("dmiss_refill_wbp", CW'(wbPending), CW'(1));
    check("dmiss_refill_memwen", CW'(memWen), CW'(0));
    refill_loop(27'h10);
    check("dmiss_fill_wen", CW'(cacheMemWen), CW'(1));
    check("dmiss_fill_dirty", CW'(cacheSetDirty), CW'(1));
    check("dmiss_fill_din", cacheDin, exp_merge);
    check("dmiss_fill_memwen", CW'(memWen), CW'(1));
    check("dmiss_fill_waddr", CW'(memBlockAddr), CW'(27'h12));
    check("dmiss_fill_wdata", memDin, victim_blk);
    next_cyc();
    ren = 1; wen = 0; cacheHit = 1; cacheDirtyBit = 0;
    sample();
    check("drain_bg_stall", CW'(stall), CW'(0));
    check("drain_bg_memwen", CW'(memWen), CW'(1));
    check("drain_bg_addr", CW'(memBlockAddr), CW'(27'h12));
    next_cyc();
    sample();
    check("drain_bg_last", CW'(memWen), CW'(1));
    next_cyc();
    sample();
    check("drain_bg_cleared", CW'(wbPending), CW'(0));
    check("drain_bg_off", CW'(memWen), CW'(0));

    // Second miss while the buffer drains
    wr_lat = 6;
    next_cyc();
    addr = 32'h300; cacheHit = 0; cacheDirtyBit = 1; cacheVictimBAddr = 27'h22; cacheDout = victim2_blk;
    sample();
    next_cyc();
    sample();
    check("m2_evict", CW'(dbg_state), CW'(ST_EVICT));
    next_cyc();
    sample();
    refill_loop(27'h18);
    check("m2_fill_memwen", CW'(memWen), CW'(1));
    next_cyc();
    cacheHit = 1; cacheDirtyBit = 0;
    sample();
    check("m2_hit_stall", CW'(stall), CW'(0));
    next_cyc();
    addr = 32'h400; cacheHit = 0;
    sample();
    check("m2_miss_stall", CW'(stall), CW'(1));
    check("m2_miss_memwen", CW'(memWen), CW'(1));
    check("m2_miss_waddr", CW'(memBlockAddr), CW'(27'h22));
    check("m2_miss_memren", CW'(memRen), CW'(0));
    n = 0;
    next_cyc();
    sample();
    while (dbg_state == ST_DRAIN && n < 20) begin
      check("drain_memwen", CW'(memWen), CW'(1));
      check("drain_memren", CW'(memRen), CW'(0));
      check("drain_stall", CW'(stall), CW'(1));
      n++;
      next_cyc();
      sample();
    end
    check("drain_cycles", CW'(n), CW'(3));
    check("m2_reeval_state", CW'(dbg_state), CW'(ST_IDLE));
    check("m2_reeval_stall", CW'(stall), CW'(1));
    check("m2_reeval_wbp", CW'(wbPending), CW'(0));
    next_cyc();
    sample();
    refill_loop(27'h20);
    check("m2_fill_din", cacheDin, refill_blk);
    next_cyc();
    cacheHit = 1;
    sample();
    check("m2_done_stall", CW'(stall), CW'(0));
    wr_lat = 3;

    // Reset in the middle of a refill drops the buffered victim
    next_cyc();
    addr = 32'h500; cacheHit = 0; cacheDirtyBit = 1; cacheVictimBAddr = 27'h33; cacheDout = victim_blk;
    sample();
    next_cyc();
    sample();
    next_cyc();
    sample();
    check("rr_refill", CW'(dbg_state), CW'(ST_REFILL));
    check("rr_wbp", CW'(wbPending), CW'(1));
    next_cyc();
    reset = 1; ren = 0; cacheDirtyBit = 0;
    sample();
    next_cyc();
    reset = 0;
    sample();
    check("rr_state", CW'(dbg_state), CW'(ST_IDLE));
    check("rr_memren", CW'(memRen), CW'(0));
    check("rr_wbp_clear", CW'(wbPending), CW'(0));
    check("rr_memwen", CW'(memWen), CW'(0));
    check("rr_stall", CW'(stall), CW'(0));

    next_cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
